// File: rtl/uart_rx_cfg_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg_sampler
//
// Parametrised UART receiver with a programmable oversample-tick divider,
// configurable frame format (5..DATA_W_MAX data bits, optional odd/even parity,
// one or two stop bits) and 3-sample majority voting around mid-bit.
// Received frames are presented through a valid/ready holding register.
// Errors are reported through sticky frame/parity/overrun flags.
//
// Ports
//   clk_sys         system clock
//   RST             asynchronous active-high reset
//   rx_bit          asynchronous serial input, idle high
//   baud_div        clk_sys cycles per oversample tick (0 behaves as 1)
//   cfg_data_bits   payload bits, clamped to 5..DATA_W_MAX
//   cfg_parity_en   parity bit present after payload
//   cfg_parity_odd  1 = odd parity, 0 = even parity
//   cfg_stop2       two stop bits are checked
//   data_rx         received payload, right-aligned, unused MSBs zero
//   data_valid      data_rx holds an unconsumed frame
//   data_ready      consumer accepts data_rx when data_valid & data_ready
//   frame_err       sticky: a stop bit was sampled low
//   parity_err      sticky: a delivered frame had a parity mismatch
//   overrun_err     sticky: a frame completed while the holding register was full
//   err_clr         clears the three sticky flags (a same-cycle set wins)
//   busy            receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg_sampler #(
  parameter int DIV_W      = 16,
  parameter int DATA_W_MAX = 8,
  parameter int OS         = 16
) (
  input  logic                  clk_sys,
  input  logic                  RST,
  input  logic                  rx_bit,
  input  logic [DIV_W-1:0]      baud_div,
  input  logic [3:0]            cfg_data_bits,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_odd,
  input  logic                  cfg_stop2,
  output logic [DATA_W_MAX-1:0] data_rx,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  input  logic                  err_clr,
  output logic                  busy
);

  localparam int SMP_W = $clog2(OS);
  localparam int CNT_W = $clog2(DATA_W_MAX + 1);

  // Oversample positions: three votes straddling mid-bit, and the bit wrap.
  localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(OS / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(OS / 2);
  localparam logic [SMP_W-1:0] SMP_C    = SMP_W'(OS / 2 + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t state_q, state_d;

  // Input synchroniser
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // Timing
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;

  // Frame configuration captured at start detection
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             stop2_q, stop2_d;

  // Frame assembly
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_W_MAX-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stop_first_q, stop_first_d;
  logic                  done_q, done_d;

  // Holding register and flags
  logic [DATA_W_MAX-1:0] data_rx_q, data_rx_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  overrun_err_q, overrun_err_d;

  // Combinational helpers
  logic [DIV_W-1:0]      div_eff;
  logic                  tick;
  logic                  at_dec;
  logic                  at_wrap;
  logic                  vote;
  logic                  start_det;
  logic [CNT_W-1:0]      nbits_cfg;
  logic [DATA_W_MAX-1:0] bit_sel;
  logic                  frame_set;
  logic                  load;

  // A zero divisor behaves as one so the tick never stalls.
  assign div_eff   = (div_q == '0) ? DIV_W'(1) : div_q;
  // >= rather than == so a freshly latched smaller divisor cannot strand div_cnt.
  assign tick      = (div_cnt_q >= (div_eff - DIV_W'(1)));
  assign at_dec    = tick && (smp_cnt_q == SMP_C);
  assign at_wrap   = tick && (smp_cnt_q == SMP_LAST);
  // Third sample is the live rx_s at the decision tick.
  assign vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  assign start_det = (state_q == S_IDLE) && !rx_s_q;

  // Clamp the requested payload width into the supported range.
  always_comb begin
    if (cfg_data_bits < 4'd5) begin
      nbits_cfg = CNT_W'(5);
    end else if (int'(cfg_data_bits) > DATA_W_MAX) begin
      nbits_cfg = CNT_W'(DATA_W_MAX);
    end else begin
      nbits_cfg = CNT_W'(cfg_data_bits);
    end
  end

  // One-hot decode of the payload bit position being received.
  generate
    for (genvar gi = 0; gi < DATA_W_MAX; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_cnt_q == CNT_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (IDLE and WAIT_HI react every cycle, others on tick)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (at_dec && vote) begin
          state_d = S_IDLE;              // glitch, not a real start bit
        end else if (at_wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // bit_cnt has already been bumped at the decision tick of the last bit.
        if (at_wrap && (bit_cnt_q == nbits_q)) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (at_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          if (!vote) begin
            state_d = S_WAIT_HI;
          end else if (!(stop2_q && !stop_first_q)) begin
            state_d = S_IDLE;            // complete mid-stop to allow back-to-back frames
          end
        end
      end
      S_WAIT_HI: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_meta_d     = rx_bit;
    rx_s_d        = rx_meta_q;

    div_cnt_d     = tick ? '0 : (div_cnt_q + DIV_W'(1));
    smp_cnt_d     = smp_cnt_q;
    s0_d          = s0_q;
    s1_d          = s1_q;

    div_d         = div_q;
    nbits_d       = nbits_q;
    par_en_d      = par_en_q;
    par_odd_d     = par_odd_q;
    stop2_d       = stop2_q;

    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_bad_d     = par_bad_q;
    stop_first_d  = stop_first_q;
    done_d        = 1'b0;
    frame_set     = 1'b0;

    data_rx_d     = data_rx_q;
    data_valid_d  = data_valid_q;

    if (tick) begin
      smp_cnt_d = (smp_cnt_q == SMP_LAST) ? '0 : (smp_cnt_q + SMP_W'(1));
      if (smp_cnt_q == SMP_A) s0_d = rx_s_q;
      if (smp_cnt_q == SMP_B) s1_d = rx_s_q;
    end

    if (start_det) begin
      smp_cnt_d    = '0;
      bit_cnt_d    = '0;
      shift_d      = '0;
      par_bad_d    = 1'b0;
      stop_first_d = 1'b0;
      div_d        = baud_div;
      nbits_d      = nbits_cfg;
      par_en_d     = cfg_parity_en;
      par_odd_d    = cfg_parity_odd;
      stop2_d      = cfg_stop2;
    end

    unique case (state_q)
      S_DATA: begin
        if (at_dec) begin
          for (int i = 0; i < DATA_W_MAX; i++) begin
            if (bit_sel[i]) shift_d[i] = vote;
          end
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        // Unused MSBs of shift_q are zero, so a full-width XOR is the payload XOR.
        if (at_dec) par_bad_d = (vote != ((^shift_q) ^ par_odd_q));
      end
      S_STOP: begin
        if (at_dec) begin
          if (!vote) begin
            frame_set = 1'b1;
          end else if (stop2_q && !stop_first_q) begin
            stop_first_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Holding register: a new load has priority over a same-cycle consume.
    load = done_q && (!data_valid_q || data_ready);
    if (load) begin
      data_rx_d    = shift_q;
      data_valid_d = 1'b1;
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    frame_err_d   = (err_clr ? 1'b0 : frame_err_q)   | frame_set;
    parity_err_d  = (err_clr ? 1'b0 : parity_err_q)  | (load && par_bad_q);
    overrun_err_d = (err_clr ? 1'b0 : overrun_err_q) | (done_q && !load);
  end

  always_ff @(posedge clk_sys or posedge RST) begin
    if (RST) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      div_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
      div_q         <= '0;
      nbits_q       <= '0;
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      stop2_q       <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      stop_first_q  <= 1'b0;
      done_q        <= 1'b0;
      data_rx_q     <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      div_cnt_q     <= div_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      div_q         <= div_d;
      nbits_q       <= nbits_d;
      par_en_q      <= par_en_d;
      par_odd_q     <= par_odd_d;
      stop2_q       <= stop2_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      stop_first_q  <= stop_first_d;
      done_q        <= done_d;
      data_rx_q     <= data_rx_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM / register outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != S_IDLE);
    data_rx     = data_rx_q;
    data_valid  = data_valid_q;
    frame_err   = frame_err_q;
    parity_err  = parity_err_q;
    overrun_err = overrun_err_q;
  end

endmodule

// File: tb/tb_uart_rx_cfg_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg_sampler
//
// Directed bench for uart_rx_cfg_sampler. Frames are serialised by the bench;
// each payload expected to be delivered is pushed to a queue when sent and
// popped when the receiver presents data_valid.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg_sampler;

  localparam int DIV_W      = 16;
  localparam int DATA_W_MAX = 8;
  localparam int OS         = 16;

  logic                  clk_sys = 1'b0;
  logic                  RST;
  logic                  rx_bit;
  logic [DIV_W-1:0]      baud_div;
  logic [3:0]            cfg_data_bits;
  logic                  cfg_parity_en;
  logic                  cfg_parity_odd;
  logic                  cfg_stop2;
  logic [DATA_W_MAX-1:0] data_rx;
  logic                  data_valid;
  logic                  data_ready;
  logic                  frame_err;
  logic                  parity_err;
  logic                  overrun_err;
  logic                  err_clr;
  logic                  busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int bit_cyc      = OS;
  logic [7:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  uart_rx_cfg_sampler #(
    .DIV_W(DIV_W),
    .DATA_W_MAX(DATA_W_MAX),
    .OS(OS)
  ) dut (
    .clk_sys(clk_sys),
    .RST(RST),
    .rx_bit(rx_bit),
    .baud_div(baud_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2),
    .data_rx(data_rx),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun_err(overrun_err),
    .err_clr(err_clr),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_bit = b;
    repeat (bit_cyc) @(negedge clk_sys);
  endtask

  // par_mode: 0 = no parity bit, 1 = correct parity, 2 = inverted parity.
  // scramble: corrupt config inputs after the start bit; the frame must still
  // be decoded with the configuration present at start detection.
  task automatic send_frame(input logic [7:0] d, input int nb, input int par_mode,
                            input logic odd, input int nstop, input logic stop_v,
                            input bit scramble);
    logic p;
    p = odd;
    drive_bit(1'b0);
    if (scramble) begin
      baud_div      = 16'd1;
      cfg_data_bits = 4'd5;
      cfg_parity_en = 1'b1;
      cfg_stop2     = 1'b1;
    end
    for (int i = 0; i < nb; i++) begin
      p = p ^ d[i];
      drive_bit(d[i]);
    end
    if (par_mode == 1) drive_bit(p);
    else if (par_mode == 2) drive_bit(~p);
    drive_bit(stop_v);
    if (nstop == 2) drive_bit(1'b1);
  endtask

  task automatic expect_frame(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (!data_valid && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_valid"}, 32'(data_valid), 32'h1);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_data"}, 32'(data_rx), 32'(e));
    $display("[TB] %s: data_rx=0x%02h expected=0x%02h", tag, data_rx, e);
  endtask

  task automatic accept(input string tag);
    data_ready = 1'b1;
    @(negedge clk_sys);
    data_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(data_valid), 32'h0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST            = 1'b1;
    rx_bit         = 1'b1;
    baud_div       = 16'd1;
    cfg_data_bits  = 4'd8;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2      = 1'b0;
    data_ready     = 1'b0;
    err_clr        = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Reset state
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_data",  32'(data_rx),    32'h0);
    chk("rst_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);
    RST = 1'b0;
    repeat (5) @(negedge clk_sys);

    // T1: 8N1 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    expect_frame("t1");
    chk("t1_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);
    accept("t1");
    chk("t1_idle", 32'(busy), 32'h0);

    // T2: 5-cycle low glitch is rejected
    rx_bit = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("t2_busy_start", 32'(busy), 32'h1);
    @(negedge clk_sys);
    rx_bit = 1'b1;
    repeat (30) @(negedge clk_sys);
    chk("t2_busy_abort", 32'(busy), 32'h0);
    chk("t2_no_valid", 32'(data_valid), 32'h0);
    chk("t2_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);

    // T3: 7 data bits, odd parity, wrong parity bit
    cfg_data_bits  = 4'd7;
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b1;
    exp_q.push_back(8'h35);
    send_frame(8'h35, 7, 2, 1'b1, 1, 1'b1, 1'b0);
    expect_frame("t3");
    chk("t3_parity_err", 32'(parity_err), 32'h1);
    chk("t3_frame_err", 32'(frame_err), 32'h0);
    pulse_clr();
    chk("t3_parity_clr", 32'(parity_err), 32'h0);
    accept("t3");

    // T4: stop bit low, line held low 40 bits, then a clean frame
    cfg_data_bits  = 4'd8;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    send_frame(8'h81, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    repeat (40 * OS) @(negedge clk_sys);
    chk("t4_frame_err", 32'(frame_err), 32'h1);
    chk("t4_no_valid", 32'(data_valid), 32'h0);
    chk("t4_wait_hi", 32'(busy), 32'h1);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("t4_idle", 32'(busy), 32'h0);
    chk("t4_sticky", 32'(frame_err), 32'h1);
    pulse_clr();
    chk("t4_clr", 32'(frame_err), 32'h0);
    repeat (OS) @(negedge clk_sys);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    expect_frame("t4");
    chk("t4_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);
    accept("t4");

    // T5: overrun, second frame dropped
    exp_q.push_back(8'h11);
    send_frame(8'h11, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    send_frame(8'h22, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    repeat (5) @(negedge clk_sys);
    expect_frame("t5");
    chk("t5_overrun", 32'(overrun_err), 32'h1);
    accept("t5");
    pulse_clr();
    chk("t5_overrun_clr", 32'(overrun_err), 32'h0);

    // T7: clamp to 5 bits, even parity correct, two stop bits
    cfg_data_bits  = 4'd3;
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b0;
    cfg_stop2      = 1'b1;
    exp_q.push_back(8'h13);
    send_frame(8'h13, 5, 1, 1'b0, 2, 1'b1, 1'b0);
    expect_frame("t7");
    chk("t7_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);
    accept("t7");

    // T8: baud_div=2, width clamp 12->8, config scrambled mid-frame
    baud_div       = 16'd2;
    bit_cyc        = 2 * OS;
    cfg_data_bits  = 4'd12;
    cfg_parity_en  = 1'b0;
    cfg_stop2      = 1'b0;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    expect_frame("t8");
    chk("t8_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);
    accept("t8");

    // T6: reset mid-payload, then baud_div=0 frame
    baud_div       = 16'd1;
    bit_cyc        = OS;
    cfg_data_bits  = 4'd8;
    cfg_parity_en  = 1'b0;
    cfg_stop2      = 1'b0;
    repeat (OS) @(negedge clk_sys);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("t6_busy_mid", 32'(busy), 32'h1);
    RST = 1'b1;
    @(negedge clk_sys);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_valid", 32'(data_valid), 32'h0);
    @(negedge clk_sys);
    RST = 1'b0;
    repeat (2 * OS) @(negedge clk_sys);
    baud_div = 16'd0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    expect_frame("t6");
    chk("t6_flags", 32'({frame_err, parity_err, overrun_err}), 32'h0);
    accept("t6");
    repeat (200) @(negedge clk_sys);
    chk("t6_no_extra", 32'(data_valid), 32'h0);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
